// File: rtl/spike_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spike_pkg
//  Description : Shared types and default constants for the spike detector:
//                FSM state encoding, default threshold/rearm codes and the
//                queued spike event record.
//  Revision    : 1.0 - initial release
// ============================================================================
package spike_pkg;

    // Detector state: armed for a crossing, holding off, or waiting to rearm
    typedef enum logic [1:0] {
        ARMED      = 2'd0,
        REFRACT    = 2'd1,
        WAIT_REARM = 2'd2
    } spike_state_t;

    // Default codes, LSB = 2^-16 V (about +30 mV and -50 mV)
    localparam int c_V_TH_CODE    = 1966;
    localparam int c_V_REARM_CODE = -3277;

    // Default timestamp width of a queued event
    localparam int c_TS_WIDTH = 16;

    // One queued spike event: the sample index at which the crossing occurred
    typedef struct packed {
        logic [c_TS_WIDTH-1:0] ts;
    } spike_event_t;

endpackage
`default_nettype wire

// File: rtl/spike_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spike_fifo
//  Description : First-word-fall-through synchronous FIFO. The head entry is
//                always visible on o_pop_data; a push into a full FIFO is
//                accepted only when a pop happens in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_ADDR_W-1:0] c_LAST = c_ADDR_W'(DEPTH - 1);
    localparam logic [c_ADDR_W:0]   c_FULL = (c_ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == c_FULL);
    assign o_empty    = (r_count == '0);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!o_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage is cleared on reset so the head reads as zero afterwards
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spike_detector.sv
`default_nettype none
// ============================================================================
//  Module      : spike_detector
//  Description : Turns the neuron membrane voltage into spike events: signed
//                threshold crossing with hysteresis, refractory hold-off,
//                one-cycle membrane reset request and a timestamped event
//                queue behind a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_detector
    import spike_pkg::*;
#(
    parameter int WIDTH         = 24,
    parameter int V_TH_CODE     = c_V_TH_CODE,
    parameter int V_REARM_CODE  = c_V_REARM_CODE,
    parameter int REFRAC_CYCLES = 16,
    parameter int TS_WIDTH      = 16,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    v_in_valid,
    input  logic signed [WIDTH-1:0] v_mem,
    output logic                    neuron_reset,
    output logic                    spike_valid,
    input  logic                    spike_ready,
    output logic [TS_WIDTH-1:0]     spike_ts,
    output logic [15:0]             spike_count,
    output logic                    overflow
);

    localparam int c_RC_W = (REFRAC_CYCLES > 1) ? $clog2(REFRAC_CYCLES) : 1;
    localparam logic [c_RC_W-1:0] c_REFRAC_LOAD =
        (REFRAC_CYCLES > 0) ? c_RC_W'(REFRAC_CYCLES - 1) : '0;
    localparam logic signed [WIDTH-1:0] c_V_TH    = WIDTH'(V_TH_CODE);
    localparam logic signed [WIDTH-1:0] c_V_REARM = WIDTH'(V_REARM_CODE);

    spike_state_t        r_state;
    logic [c_RC_W-1:0]   r_refrac_cnt;
    logic [TS_WIDTH-1:0] r_ts_cnt;
    logic                r_neuron_reset;
    logic [15:0]         r_spike_count;
    logic                r_overflow;

    logic w_fire;
    logic w_pop;
    logic w_full;
    logic w_empty;

    // Only an armed detector fires; both compares are full-width signed
    assign w_fire = (r_state == ARMED) && v_in_valid && (v_mem >= c_V_TH);
    assign w_pop  = !w_empty && spike_ready;

    assign neuron_reset = r_neuron_reset;
    assign spike_valid  = !w_empty;
    assign spike_count  = r_spike_count;
    assign overflow     = r_overflow;

    // Sample index counter; events carry the value before this increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts_cnt <= '0;
        end else if (v_in_valid) begin
            r_ts_cnt <= r_ts_cnt + 1'b1;
        end
    end

    // Hysteresis FSM with refractory countdown independent of sample strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ARMED;
            r_refrac_cnt <= '0;
        end else begin
            case (r_state)
                ARMED: begin
                    if (w_fire) begin
                        if (REFRAC_CYCLES > 0) begin
                            r_state      <= REFRACT;
                            r_refrac_cnt <= c_REFRAC_LOAD;
                        end else begin
                            r_state <= WAIT_REARM;
                        end
                    end
                end
                REFRACT: begin
                    if (r_refrac_cnt == '0) begin
                        r_state <= WAIT_REARM;
                    end else begin
                        r_refrac_cnt <= r_refrac_cnt - 1'b1;
                    end
                end
                WAIT_REARM: begin
                    if (v_in_valid && (v_mem <= c_V_REARM)) begin
                        r_state <= ARMED;
                    end
                end
                default: r_state <= ARMED;
            endcase
        end
    end

    // Fire side effects: reset pulse, saturating count, sticky drop flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_neuron_reset <= 1'b0;
            r_spike_count  <= '0;
            r_overflow     <= 1'b0;
        end else begin
            r_neuron_reset <= w_fire;
            if (w_fire && (r_spike_count != 16'hFFFF)) begin
                r_spike_count <= r_spike_count + 1'b1;
            end
            if (w_fire && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    spike_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (TS_WIDTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fire),
        .i_push_data (r_ts_cnt),
        .i_pop       (w_pop),
        .o_pop_data  (spike_ts),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_spike_detector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_detector
//  Description : Directed self-checking bench for spike_detector: a ramp
//                vector table plus hand sequences for hold, refractory
//                length, zero-refractory, queue overflow, full push/pop and
//                mid-operation reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_detector;

    typedef struct {
        logic               vv;
        logic signed [23:0] v;
        logic               rdy;
        logic               e_nr;
        logic               e_val;
        logic [15:0]        e_ts;
        logic [15:0]        e_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // Main instance (REFRAC_CYCLES = 16)
    logic               v_valid = 1'b0;
    logic signed [23:0] v_mem = '0;
    logic               rdy = 1'b0;
    logic               nr;
    logic               sv;
    logic [15:0]        sts;
    logic [15:0]        scnt;
    logic               ovf;

    // Zero-refractory instance
    logic               v0_valid = 1'b0;
    logic signed [23:0] v0_mem = '0;
    logic               rdy0 = 1'b1;
    logic               nr0;
    logic               sv0;
    logic [15:0]        sts0;
    logic [15:0]        scnt0;
    logic               ovf0;

    int checks = 0;
    int errors = 0;
    int sample_idx = 0;
    vec_t vecs[7];

    always #5 clk = ~clk;

    spike_detector #(
        .WIDTH(24), .V_TH_CODE(1966), .V_REARM_CODE(-3277),
        .REFRAC_CYCLES(16), .TS_WIDTH(16), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .v_in_valid(v_valid), .v_mem(v_mem),
        .neuron_reset(nr), .spike_valid(sv), .spike_ready(rdy),
        .spike_ts(sts), .spike_count(scnt), .overflow(ovf)
    );

    spike_detector #(
        .WIDTH(24), .V_TH_CODE(1966), .V_REARM_CODE(-3277),
        .REFRAC_CYCLES(0), .TS_WIDTH(16), .FIFO_DEPTH(4)
    ) dut0 (
        .clk(clk), .rst_n(rst_n), .v_in_valid(v0_valid), .v_mem(v0_mem),
        .neuron_reset(nr0), .spike_valid(sv0), .spike_ready(rdy0),
        .spike_ts(sts0), .spike_count(scnt0), .overflow(ovf0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One sample on the main instance; outputs are read 1 time unit after the edge
    task automatic drive(input logic vv, input logic signed [23:0] v, input logic r);
        v0_valid = 1'b0;
        v_valid  = vv;
        v_mem    = v;
        rdy      = r;
        @(posedge clk);
        #1;
        if (vv) sample_idx++;
    endtask

    task automatic drive0(input logic vv, input logic signed [23:0] v);
        v_valid  = 1'b0;
        v0_valid = vv;
        v0_mem   = v;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        v_valid  = 1'b0;
        v0_valid = 1'b0;
        rdy      = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        sample_idx = 0;
    endtask

    // Fire, sit out the refractory window, then rearm: 18 samples per spike
    task automatic fire_once(input logic r);
        drive(1'b1, 24'sd3000, r);
        repeat (16) drive(1'b1, 24'sd0, 1'b0);
        drive(1'b1, -24'sd4000, 1'b0);
    endtask

    task automatic drain(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                         input logic [15:0] e2, input logic [15:0] e3);
        logic [15:0] exp_ts [4];
        exp_ts[0] = e0; exp_ts[1] = e1; exp_ts[2] = e2; exp_ts[3] = e3;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_valid%0d", tag, k), sv, 1);
            chk($sformatf("%s_ts%0d", tag, k), sts, exp_ts[k]);
            drive(1'b0, 24'sd0, 1'b1);
        end
        chk($sformatf("%s_empty", tag), sv, 0);
    endtask

    initial begin
        int pulses;

        // Ramp: crossing at sample index 5 (1966 >= threshold, 1965 below)
        vecs[0] = '{1'b1, -24'sd3277, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[1] = '{1'b1, -24'sd1000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[2] = '{1'b1,  24'sd0,    1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[3] = '{1'b1,  24'sd1000, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[4] = '{1'b1,  24'sd1965, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0};
        vecs[5] = '{1'b1,  24'sd1966, 1'b1, 1'b1, 1'b1, 16'd5, 16'd1};
        vecs[6] = '{1'b1,  24'sd2500, 1'b1, 1'b0, 1'b0, 16'd0, 16'd1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_nreset", nr, 0);
        chk("rst_valid", sv, 0);
        chk("rst_ts", sts, 0);
        chk("rst_count", scnt, 0);
        chk("rst_overflow", ovf, 0);
        rst_n = 1'b1;
        sample_idx = 0;

        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].vv, vecs[i].v, vecs[i].rdy);
            chk($sformatf("ramp%0d_nreset", i), nr, vecs[i].e_nr);
            chk($sformatf("ramp%0d_valid", i), sv, vecs[i].e_val);
            if (vecs[i].e_val) chk($sformatf("ramp%0d_ts", i), sts, vecs[i].e_ts);
            chk($sformatf("ramp%0d_count", i), scnt, vecs[i].e_cnt);
        end

        // Holding above threshold never refires without a rearm
        pulses = 0;
        repeat (100) begin
            drive(1'b1, 24'sd3000, 1'b1);
            if (nr) pulses++;
        end
        chk("hold_no_refire", pulses, 0);
        chk("hold_count", scnt, 1);
        drive(1'b1, -24'sd4000, 1'b1);
        drive(1'b1, 24'sd3000, 1'b1);
        chk("refire_nreset", nr, 1);
        chk("refire_valid", sv, 1);
        chk("refire_ts", sts, 108);
        chk("refire_count", scnt, 2);

        // Samples 1..16 after a fire fall in the refractory window
        repeat (16) drive(1'b1, -24'sd4000, 1'b1);
        drive(1'b1, 24'sd3000, 1'b1);
        chk("refrac_early_no_fire", nr, 0);
        drive(1'b1, -24'sd4000, 1'b1);
        drive(1'b1, 24'sd3000, 1'b1);
        chk("refrac_rearm_fire", nr, 1);
        chk("refrac_rearm_ts", sts, 127);
        chk("refrac_rearm_count", scnt, 3);

        // Zero refractory: fire, rearm, fire on consecutive samples
        drive0(1'b1, 24'sd3000);
        chk("r0_fire1_nreset", nr0, 1);
        chk("r0_fire1_ts", sts0, 0);
        drive0(1'b1, -24'sd4000);
        chk("r0_rearm_nreset", nr0, 0);
        drive0(1'b1, 24'sd3000);
        chk("r0_fire2_nreset", nr0, 1);
        chk("r0_fire2_valid", sv0, 1);
        chk("r0_fire2_ts", sts0, 2);
        chk("r0_fire2_count", scnt0, 2);
        drive0(1'b0, 24'sd0);

        // Six fires into a stalled queue: first four kept, rest dropped
        do_reset();
        for (int f = 0; f < 6; f++) begin
            fire_once(1'b0);
            if (f == 3) chk("ovf_not_yet", ovf, 0);
        end
        chk("ovf_set", ovf, 1);
        chk("ovf_count", scnt, 6);
        drain("ovf_drain", 16'd0, 16'd18, 16'd36, 16'd54);
        chk("ovf_sticky", ovf, 1);

        // Full queue with push and pop in the same cycle: nothing dropped
        do_reset();
        repeat (4) fire_once(1'b0);
        fire_once(1'b1);
        chk("fullpp_overflow", ovf, 0);
        chk("fullpp_count", scnt, 5);
        drain("fullpp_drain", 16'd18, 16'd36, 16'd54, 16'd72);

        // Reset during refractory with two queued events
        do_reset();
        drive(1'b1, 24'sd0, 1'b0);
        fire_once(1'b0);
        drive(1'b1, 24'sd3000, 1'b0);
        chk("prereset_nreset", nr, 1);
        chk("prereset_ts", sts, 1);
        chk("prereset_count", scnt, 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_nreset", nr, 0);
        chk("midrst_valid", sv, 0);
        chk("midrst_ts", sts, 0);
        chk("midrst_count", scnt, 0);
        chk("midrst_overflow", ovf, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sample_idx = 0;
        drive(1'b1, -24'sd100, 1'b1);
        drive(1'b1, 24'sd0, 1'b1);
        drive(1'b1, 24'sd3000, 1'b1);
        chk("postrst_nreset", nr, 1);
        chk("postrst_valid", sv, 1);
        chk("postrst_ts", sts, 2);
        chk("postrst_count", scnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
